// File: rtl/umips_muldiv_wb_if.sv
// Handshake and register-file write-port bundle for the iterative mul/div unit.
// master = execute stage / pipeline side, slave = umips_muldiv_wb.
interface umips_muldiv_wb_if;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  dst;
    logic        busy;
    logic        done;
    logic        pipe_we;
    logic [4:0]  pipe_a;
    logic [31:0] pipe_wd;
    logic        rf_we;
    logic [4:0]  rf_a;
    logic [31:0] rf_wd;

    modport master (
        output start, op, a, b, dst, pipe_we, pipe_a, pipe_wd,
        input  busy, done, rf_we, rf_a, rf_wd
    );

    modport slave (
        input  start, op, a, b, dst, pipe_we, pipe_a, pipe_wd,
        output busy, done, rf_we, rf_a, rf_wd
    );
endinterface

// File: rtl/umips_muldiv_wb.sv
// Iterative 32-cycle multiply / restoring divide unit sharing the register-file write port.
// Define UMIPS_MULDIV_DIV_EN to include DIVU/REMU; otherwise divide requests are dropped.
//
// state | meaning
// IDLE  | waiting for an accepted start
// RUN   | one shift-add / restoring-divide iteration per cycle, 32 cycles
// WB    | result presented; retires on first cycle without a pipeline write
module umips_muldiv_wb (
    input logic             clk,
    input logic             rst,
    umips_muldiv_wb_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, WB} state_t;

    state_t      state;
    state_t      state_nx;
    logic [63:0] acc;
    logic [63:0] acc_nx;
    logic [63:0] mul_nx;
    logic [32:0] sum;
    logic [31:0] a_q;
    logic [31:0] shreg;
    logic [4:0]  dst_q;
    logic [5:0]  cnt;
    logic [31:0] result;
    logic        accept;
    logic        last_iter;
    logic        retire;
`ifdef UMIPS_MULDIV_DIV_EN
    logic [1:0]  op_q;
    logic [31:0] b_q;
    logic [32:0] rem_sh;
    logic [33:0] diff;
    logic [63:0] div_nx;
    logic        is_div;
    logic        op_div;
`endif

`ifdef UMIPS_MULDIV_DIV_EN
    assign op_div = (bus.op == 2'd1) || (bus.op == 2'd2);
    assign accept = bus.start && (state == IDLE);
    assign is_div = (op_q == 2'd1) || (op_q == 2'd2);
`else
    assign accept = bus.start && (state == IDLE) && !((bus.op == 2'd1) || (bus.op == 2'd2));
`endif

    assign last_iter = (cnt == 6'd31);

    // Multiply: multiplicand added into the upper half, product shifts down into the lower half.
    always_comb begin
        sum    = {1'b0, acc[63:32]} + {1'b0, (shreg[0] ? a_q : 32'd0)};
        mul_nx = {sum, acc[31:1]};
    end

`ifdef UMIPS_MULDIV_DIV_EN
    // Divide: remainder in acc[63:32], quotient in acc[31:0], dividend bits fed from shreg MSB.
    always_comb begin
        rem_sh = {acc[63:32], shreg[31]};
        diff   = {1'b0, rem_sh} - {2'b00, b_q};
        if (diff[33])
            div_nx = {rem_sh[31:0], acc[30:0], 1'b0};
        else
            div_nx = {diff[31:0], acc[30:0], 1'b1};
        acc_nx = is_div ? div_nx : mul_nx;
        case (op_q)
            2'd2:    result = acc[63:32];
            default: result = acc[31:0];
        endcase
    end
`else
    always_comb begin
        acc_nx = mul_nx;
        result = acc[31:0];
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_q   <= '0;
            shreg <= '0;
            dst_q <= '0;
            acc   <= '0;
            cnt   <= '0;
`ifdef UMIPS_MULDIV_DIV_EN
            b_q   <= '0;
            op_q  <= '0;
`endif
        end else if (accept) begin
            a_q   <= bus.a;
            dst_q <= bus.dst;
            acc   <= '0;
            cnt   <= '0;
`ifdef UMIPS_MULDIV_DIV_EN
            b_q   <= bus.b;
            op_q  <= bus.op;
            shreg <= op_div ? bus.a : bus.b;
`else
            shreg <= bus.b;
`endif
        end else if (state == RUN) begin
            cnt <= cnt + 6'd1;
            acc <= acc_nx;
`ifdef UMIPS_MULDIV_DIV_EN
            shreg <= is_div ? {shreg[30:0], 1'b0} : {1'b0, shreg[31:1]};
`else
            shreg <= {1'b0, shreg[31:1]};
`endif
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept)    state_nx = RUN;
            RUN:     if (last_iter) state_nx = WB;
            WB:      if (retire)    state_nx = IDLE;
            default:                state_nx = IDLE;
        endcase
    end

    // Pipeline writeback always wins the port; a dst=0 result retires without writing.
    always_comb begin
        retire    = (state == WB) && ((dst_q == 5'd0) || !bus.pipe_we);
        bus.busy  = (state != IDLE);
        bus.done  = retire;
        bus.rf_we = bus.pipe_we;
        bus.rf_a  = bus.pipe_a;
        bus.rf_wd = bus.pipe_wd;
        if (!bus.pipe_we && (state == WB) && (dst_q != 5'd0)) begin
            bus.rf_we = 1'b1;
            bus.rf_a  = dst_q;
            bus.rf_wd = result;
        end
    end
endmodule

// File: tb/tb_umips_muldiv_wb.sv
// Directed bench for umips_muldiv_wb: MUL, DIVU/REMU or divide-drop, write-port conflict, busy start, dst=0, reset abort.
module tb_umips_muldiv_wb;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    umips_muldiv_wb_if bus ();

    umips_muldiv_wb dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Issue at a negedge so edge 0 accepts; returns in cycle 1 (after the first negedge).
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] dst);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        bus.dst   = dst;
        @(negedge clk);
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.op    = '0;
        bus.dst   = '0;
        #1;
    endtask

    task automatic run_check(input string tag, input logic [1:0] op, input logic [31:0] a,
                             input logic [31:0] b, input logic [4:0] dst, input logic [31:0] exp);
        issue(op, a, b, dst);
        chk({tag, "_busy1"}, bus.busy, 1'b1);
        repeat (31) @(negedge clk);
        #1;
        chk({tag, "_we32"}, bus.rf_we, 1'b0);
        @(negedge clk);
        #1;
        chk({tag, "_we33"}, bus.rf_we, 1'b1);
        chk({tag, "_a33"}, bus.rf_a, dst);
        chk({tag, "_wd33"}, bus.rf_wd, exp);
        chk({tag, "_done33"}, bus.done, 1'b1);
        @(negedge clk);
        #1;
        chk({tag, "_busy34"}, bus.busy, 1'b0);
        chk({tag, "_done34"}, bus.done, 1'b0);
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        rst         = 1'b0;
        bus.start   = 1'b0;
        bus.op      = '0;
        bus.a       = '0;
        bus.b       = '0;
        bus.dst     = '0;
        bus.pipe_we = 1'b0;
        bus.pipe_a  = 5'd0;
        bus.pipe_wd = '0;
        #1;
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_done", bus.done, 1'b0);
        chk("rst_we", bus.rf_we, 1'b0);
        bus.pipe_we = 1'b1;
        bus.pipe_a  = 5'd17;
        bus.pipe_wd = 32'h1234_5678;
        #1;
        chk("rst_pass_we", bus.rf_we, 1'b1);
        chk("rst_pass_a", bus.rf_a, 5'd17);
        chk("rst_pass_wd", bus.rf_wd, 32'h1234_5678);
        bus.pipe_we = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;

        run_check("mul7x6", 2'd0, 32'd7, 32'd6, 5'd3, 32'd42);
        run_check("mulwrap", 2'd0, 32'hFFFF_FFFF, 32'd2, 5'd5, 32'hFFFF_FFFE);
        run_check("mulbig", 2'd0, 32'h0001_0003, 32'h0002_0005, 5'd31, 32'h000B_000F);
        run_check("op3mul", 2'd3, 32'd5, 32'd9, 5'd7, 32'd45);

`ifdef UMIPS_MULDIV_DIV_EN
        run_check("divu", 2'd1, 32'd100, 32'd7, 5'd4, 32'd14);
        run_check("remu", 2'd2, 32'd100, 32'd7, 5'd4, 32'd2);
        run_check("divu0", 2'd1, 32'd100, 32'd0, 5'd4, 32'hFFFF_FFFF);
        run_check("remu0", 2'd2, 32'd100, 32'd0, 5'd4, 32'd100);
        run_check("divbig", 2'd1, 32'hFFFF_FFFF, 32'h0001_0000, 5'd10, 32'h0000_FFFF);
`else
        issue(2'd1, 32'd100, 32'd7, 5'd4);
        for (int i = 0; i < 40; i++) begin
            chk("nodiv1_busy_done", {bus.busy, bus.done, bus.rf_we}, 3'b000);
            @(negedge clk);
            #1;
        end
        issue(2'd2, 32'd100, 32'd7, 5'd4);
        for (int i = 0; i < 40; i++) begin
            chk("nodiv2_busy_done", {bus.busy, bus.done, bus.rf_we}, 3'b000);
            @(negedge clk);
            #1;
        end
        run_check("nodiv_mul", 2'd0, 32'd11, 32'd13, 5'd2, 32'd143);
`endif

        // Pipeline holds the port for cycles 33-35; unit writes in 36.
        issue(2'd0, 32'd3, 32'd4, 5'd6);
        repeat (32) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            bus.pipe_we = 1'b1;
            bus.pipe_a  = 5'd9;
            bus.pipe_wd = 32'hA5A5_0000 + k;
            #1;
            chk("cfl_we", bus.rf_we, 1'b1);
            chk("cfl_a", bus.rf_a, 5'd9);
            chk("cfl_wd", bus.rf_wd, 32'hA5A5_0000 + k);
            chk("cfl_done", bus.done, 1'b0);
            chk("cfl_busy", bus.busy, 1'b1);
            @(negedge clk);
        end
        bus.pipe_we = 1'b0;
        bus.pipe_a  = 5'd0;
        bus.pipe_wd = '0;
        #1;
        chk("cfl36_we", bus.rf_we, 1'b1);
        chk("cfl36_a", bus.rf_a, 5'd6);
        chk("cfl36_wd", bus.rf_wd, 32'd12);
        chk("cfl36_done", bus.done, 1'b1);
        @(negedge clk);
        #1;
        chk("cfl37_busy", bus.busy, 1'b0);

        // Start pulsed at cycle 10 while busy must be ignored.
        issue(2'd0, 32'd10, 32'd11, 5'd8);
        repeat (9) @(negedge clk);
        bus.start = 1'b1;
        bus.op    = 2'd0;
        bus.a     = 32'd1000;
        bus.b     = 32'd1000;
        bus.dst   = 5'd2;
        @(negedge clk);
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.dst   = '0;
        repeat (22) @(negedge clk);
        #1;
        chk("ign_we", bus.rf_we, 1'b1);
        chk("ign_a", bus.rf_a, 5'd8);
        chk("ign_wd", bus.rf_wd, 32'd110);
        chk("ign_done", bus.done, 1'b1);
        @(negedge clk);
        #1;
        chk("ign_busy34", bus.busy, 1'b0);

        // dst=0: no write at any point, done still pulses at cycle 33.
        issue(2'd0, 32'd2, 32'd3, 5'd0);
        for (int c = 1; c <= 33; c++) begin
            chk("dst0_we", bus.rf_we, 1'b0);
            if (c < 33) begin
                @(negedge clk);
                #1;
            end
        end
        chk("dst0_done33", bus.done, 1'b1);
        @(negedge clk);
        #1;
        chk("dst0_busy34", bus.busy, 1'b0);

        // Reset at cycle 15 aborts the operation.
        issue(2'd0, 32'd7, 32'd7, 5'd1);
        repeat (14) @(negedge clk);
        rst         = 1'b0;
        bus.pipe_we = 1'b1;
        bus.pipe_a  = 5'd12;
        bus.pipe_wd = 32'hDEAD_BEEF;
        #1;
        chk("rmid_busy", bus.busy, 1'b0);
        chk("rmid_we", bus.rf_we, 1'b1);
        chk("rmid_a", bus.rf_a, 5'd12);
        chk("rmid_wd", bus.rf_wd, 32'hDEAD_BEEF);
        @(negedge clk);
        bus.pipe_we = 1'b0;
        bus.pipe_a  = 5'd0;
        bus.pipe_wd = '0;
        rst         = 1'b1;
        for (int i = 0; i < 40; i++) begin
            #1;
            chk("rpost_we_done_busy", {bus.rf_we, bus.done, bus.busy}, 3'b000);
            @(negedge clk);
        end

        run_check("post_rst_mul", 2'd0, 32'd9, 32'd9, 5'd30, 32'd81);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/umips_muldiv_wb.md
# umips_muldiv_wb

Iterative multiply/divide unit that acts as a second writer into the register file's single write port. It accepts an operation from the execute stage, computes it over 32 cycles, then drives the result into the register file write port (write enable, address, data). It merges its write with the pipeline's normal writeback, and the pipeline always has priority.

## Interface
- Parameters: none.
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- start  in  1  operation request; accepted only when busy=0.
- op  in  2  operation: 0=MUL (low 32 bits of unsigned product), 1=DIVU quotient, 2=REMU remainder, 3=reserved (executes as MUL).
- a  in  32  operand A / dividend, sampled on accept.
- b  in  32  operand B / divisor, sampled on accept.
- dst  in  5  destination register index, sampled on accept.
- busy  out  1  high from the cycle after accept until the unit's write is retired.
- done  out  1  one-cycle pulse in the cycle the result is retired.
- pipe_we  in  1  pipeline writeback enable.
- pipe_a  in  5  pipeline writeback address.
- pipe_wd  in  32  pipeline writeback data.
- rf_we  out  1  to register file write enable.
- rf_a  out  5  to register file write address.
- rf_wd  out  32  to register file write data.

## Operation
- States: IDLE, RUN, WB.
- IDLE:
  - start=1 latches a, b, op, dst.
  - Clears the 64-bit accumulator and the 6-bit iteration counter.
  - Next state RUN.
- RUN: one iteration per cycle; after the 32nd iteration, next state WB.
  - MUL: shift-add. If multiplier bit 0 = 1, add the multiplicand to the upper half of the accumulator with carry. Then shift the accumulator right by 1.
  - DIVU/REMU: restoring division. Shift remainder:quotient left by 1. Trial-subtract the divisor from the 33-bit remainder. If the result is non-negative, keep it and set quotient bit 0.
  - Divide by zero: no special path; restoring division yields quotient 0xFFFFFFFF and remainder = a.
- WB: unit presents its result; it retires on the first cycle with pipe_we=0.
  - On retire: done=1, next state IDLE.
  - dst=0: the unit never asserts rf_we. It retires in the first WB cycle regardless of pipe_we, and done still pulses.
- Output mux (combinational):
  - pipe_we=1: rf_we/rf_a/rf_wd = pipe_we/pipe_a/pipe_wd.
  - Otherwise, in WB with dst≠0: 1/dst/result.
  - Otherwise: rf_we=0; rf_a and rf_wd follow the pipe inputs.
- start while busy=1 is ignored; no queueing.
- A pipeline write to dst during RUN is not checked and is overwritten by the later unit write. Hazard avoidance belongs to the stall logic via busy.

## Timing
- Reset: state=IDLE, busy=0, done=0, counter=0, accumulator=0, latched operands=0.
- During reset, rf_* follow the pipe inputs (combinational pass-through).
- Reset asserted mid-RUN or mid-WB aborts the operation; no write is issued afterwards.
- Cycle numbering: start accepted at edge 0.
  - busy=1 from cycle 1.
  - RUN occupies cycles 1–32.
  - WB begins at cycle 33.
  - With no pipe conflict, the write and done both occur in cycle 33, and busy falls at edge 34.
- Each cycle with pipe_we=1 in WB delays retirement by exactly one cycle.
- Back-to-back use: a new start is accepted in the first IDLE cycle (cycle 34 at the earliest).

## Configuration
- UMIPS_MULDIV_DIV_EN defined: DIVU and REMU are supported as described.
- Not defined: divide hardware is omitted.
  - op=1 or op=2 with start=1 is dropped: no state change, busy stays 0, no write, no done.
  - MUL is unaffected.

## Test plan
- MUL: a=7, b=6, dst=3, no pipe traffic. Expect rf_we=1, rf_a=3, rf_wd=42 and done=1 at cycle 33; busy=0 at cycle 34.
- MUL wrap: a=0xFFFFFFFF, b=2, dst=5. Expect rf_wd=0xFFFFFFFE (low 32 bits only).
- DIVU/REMU (DIV_EN set): a=100, b=7.
  - DIVU, dst=4: expect 14 written.
  - REMU, dst=4: expect 2 written.
  - DIVU, b=0: expect 0xFFFFFFFF.
  - REMU, b=0: expect 100.
- Conflict: hold pipe_we=1 with pipe_a=9 for cycles 33–35.
  - Expect the pipe writes to pass through unchanged in those cycles.
  - Expect the unit write and done in cycle 36.
- start pulsed at cycle 10 with different operands while busy: expect it ignored and the original result written.
- dst=0: done pulses at cycle 33 and rf_we stays 0 throughout.
- Reset: rst low at cycle 15 → busy=0 immediately; no rf_we from the unit afterwards.
- DIV_EN undefined: start with op=1 → busy stays 0 and no done occurs.
